// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle digit-serial adder/subtractor with start/busy/done handshake
//
// Purpose: adds or subtracts two WIDTH-bit operands by reusing one DIGIT-bit
// ripple slice over WIDTH/DIGIT cycles, least significant digit first.
//
// Ports:
//   clk       - clock, all state changes on the rising edge
//   reset     - synchronous active-high reset
//   start     - request, sampled only while idle
//   a, b      - operands, captured on the accepted start
//   carryIn   - carry-in (add) / borrow-in (subtract)
//   sub       - 0 = add, 1 = subtract
//   sum       - registered result, held until the next result is written
//   carryOut  - carry-out (add) / borrow-out (subtract)
//   overflow  - two's-complement signed overflow
//   busy      - high while digits are being processed
//   done      - one-cycle pulse when results are newly valid

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryIn,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic             r_sub;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry_out;
    logic             r_overflow;

    logic [DIGIT:0]   w_slice;
    logic             w_msb_cin;
    logic             w_last;
    logic [WIDTH-1:0] w_digit_ext;
    logic [WIDTH-1:0] w_res_next;

    // One DIGIT-bit slice; the operand registers shift right so the active
    // digit always sits in the low bits.
    assign w_slice = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, r_carry};

    // Carry into the top bit of the current digit, recovered from the sum bit.
    // On the last digit this is the carry into bit WIDTH-1.
    assign w_msb_cin = w_slice[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];

    assign w_last = (r_cnt == LAST_DIGIT);

    // New digit enters at the top; after NDIG shifts the result is aligned.
    assign w_digit_ext = WIDTH'(w_slice[DIGIT-1:0]);
    assign w_res_next  = (r_res >> DIGIT) | (w_digit_ext << (WIDTH - DIGIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_carry     <= 1'b0;
            r_sub       <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // a - b - borrow == a + ~b + (1 - borrow)
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= carryIn ^ sub;
                        r_sub   <= sub;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_slice[DIGIT];
                    r_res   <= w_res_next;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_sum       <= w_res_next;
                        r_carry_out <= w_slice[DIGIT] ^ r_sub;
                        r_overflow  <= w_msb_cin ^ w_slice[DIGIT];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum      = r_sum;
    assign carryOut = r_carry_out;
    assign overflow = r_overflow;
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (8x1 and 4x2 configurations)

module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;

    logic       start8;
    logic [7:0] a8, b8;
    logic       cin8, sub8;
    logic [7:0] sum8;
    logic       co8, ov8, busy8, done8;

    logic       start4;
    logic [3:0] a4, b4;
    logic       cin4, sub4;
    logic [3:0] sum4;
    logic       co4, ov4, busy4, done4;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
        .carryIn(cin8), .sub(sub8), .sum(sum8), .carryOut(co8),
        .overflow(ov8), .busy(busy8), .done(done8)
    );

    serial_adder #(.WIDTH(4), .DIGIT(2)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
        .carryIn(cin4), .sub(sub4), .sum(sum4), .carryOut(co4),
        .overflow(ov4), .busy(busy4), .done(done4)
    );

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] exp_sum;
        logic       exp_co;
        logic       exp_ov;
    } vec_t;

    vec_t vecs[8];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one 8-bit operation; inputs are scrambled after acceptance to
    // confirm they are captured.
    task automatic op8(input vec_t v);
        int busy_ok;
        busy_ok = 1;
        @(negedge clk);
        a8 = v.a; b8 = v.b; cin8 = v.cin; sub8 = v.sub; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = ~v.a; b8 = ~v.b; cin8 = ~v.cin; sub8 = ~v.sub;
        for (int k = 0; k < 8; k++) begin
            if (!(busy8 === 1'b1 && done8 === 1'b0)) busy_ok = 0;
            @(negedge clk);
        end
        chk({v.name, " busy8"}, busy_ok, 1);
        chk({v.name, " done8"}, {busy8, done8}, 2'b01);
        chk({v.name, " sum8"}, sum8, v.exp_sum);
        chk({v.name, " co8"}, co8, v.exp_co);
        chk({v.name, " ov8"}, ov8, v.exp_ov);
    endtask

    task automatic op4(input int ai, input int bi, input int ci, input int si);
        int busy_ok;
        int raw;
        int sa, sb, sr;
        logic [3:0] es;
        logic eco, eov;
        busy_ok = 1;
        if (si == 0) raw = ai + bi + ci;
        else         raw = ai + (15 - bi) + (1 - ci);
        es  = 4'(raw);
        eco = (si == 0) ? (raw >= 16) : (raw < 16);
        sa  = (ai >= 8) ? ai - 16 : ai;
        sb  = (bi >= 8) ? bi - 16 : bi;
        sr  = (si == 0) ? sa + sb + ci : sa - sb - ci;
        eov = (sr > 7) || (sr < -8);
        @(negedge clk);
        a4 = 4'(ai); b4 = 4'(bi); cin4 = ci[0]; sub4 = si[0]; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; a4 = ~a4; b4 = ~b4; cin4 = ~cin4; sub4 = ~sub4;
        for (int k = 0; k < 2; k++) begin
            if (!(busy4 === 1'b1 && done4 === 1'b0)) busy_ok = 0;
            @(negedge clk);
        end
        chk($sformatf("w4 %0d %0d c%0d s%0d busy", ai, bi, ci, si), busy_ok, 1);
        chk($sformatf("w4 %0d %0d c%0d s%0d done", ai, bi, ci, si), {busy4, done4}, 2'b01);
        chk($sformatf("w4 %0d %0d c%0d s%0d result", ai, bi, ci, si),
            {sum4, co4, ov4}, {es, eco, eov});
    endtask

    initial begin
        int n;
        int ok;
        int dq[$];

        vecs[0] = '{"add 3C+0F", 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0};
        vecs[1] = '{"add FF+01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{"add 7F+01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{"add 00+00+1", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[4] = '{"sub 10-20", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0};
        vecs[5] = '{"sub 80-01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1};
        vecs[6] = '{"sub 05-05-1", 8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{"add 80+80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

        // Reset held with start asserted
        reset = 1'b1;
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; sub8 = 1'b0;
        start4 = 1'b1; a4 = 4'h3; b4 = 4'h5; cin4 = 1'b0; sub4 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("reset outputs8", {sum8, co8, ov8, busy8, done8}, 12'h000);
            chk("reset outputs4", {sum4, co4, ov4, busy4, done4}, 8'h00);
        end
        reset = 1'b0; start8 = 1'b0; start4 = 1'b0;
        ok = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (busy8 !== 1'b0 || done8 !== 1'b0) ok = 0;
        end
        chk("idle without start", ok, 1);

        foreach (vecs[i]) op8(vecs[i]);

        // Start pulsed during RUN is ignored
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        @(negedge clk);
        start8 = 1'b0;
        n = 4;
        while (done8 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ignored start latency", n, 9);
        chk("ignored start sum", sum8, 8'h02);
        ok = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (busy8 !== 1'b0 || done8 !== 1'b0) ok = 0;
        end
        chk("no op from RUN start", ok, 1);

        // Reset in RUN cycle 4 aborts the operation
        @(negedge clk);
        a8 = 8'h3C; b8 = 8'h0F; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort outputs", {sum8, co8, ov8, busy8, done8}, 12'h000);
        ok = 1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8 !== 1'b0 || busy8 !== 1'b0) ok = 0;
        end
        chk("abort no done", ok, 1);

        // Start held high: done every 10 cycles
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (done8 === 1'b1) dq.push_back(k);
        end
        chk("held start done count", dq.size(), 4);
        ok = (dq.size() >= 2) ? 1 : 0;
        for (int i = 1; i < dq.size(); i++) begin
            if (dq[i] - dq[i-1] != 10) ok = 0;
        end
        chk("held start interval 10", ok, 1);
        chk("held start sum", sum8, 8'h03);
        start8 = 1'b0;
        for (int k = 0; k < 12; k++) @(negedge clk);
        chk("drained idle", {busy8, done8}, 2'b00);

        // Exhaustive 4-bit, 2-bit-digit sweep against the bench model
        for (int ai = 0; ai < 16; ai++)
            for (int bi = 0; bi < 16; bi++)
                for (int ci = 0; ci < 2; ci++)
                    for (int si = 0; si < 2; si++)
                        op4(ai, bi, ci, si);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
